reg_addr_decode_stage: RTL and testbench

- Pipelined successor to the combinational register-address extractor in the MIPS decode path.
- Decodes rs, rt and the real destination register for each instruction format, with an explicit write-enable.
- Holds the result in a valid/ready output register and stalls the input on load-use hazards over a parametrised window.
- Sits between instruction fetch and the register file / ID-EX boundary.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/reg_dst_decoder.sv | 60 ++++++
 rtl/reg_addr_decode_stage.sv | 137 +++++++++++++
 tb/tb_reg_addr_decode_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the load-use scoreboard entry type.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LB    = 6'h20;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_LHU   = 6'h25;
  localparam logic [OPCODE_W-1:0] OP_SB    = 6'h28;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] addr;
  } sb_entry_t;

  function automatic logic op_in_range(input logic [OPCODE_W-1:0] op,
                                       input logic [OPCODE_W-1:0] lo,
                                       input logic [OPCODE_W-1:0] hi);
    return (op >= lo) && (op <= hi);
  endfunction

endpackage

// File: rtl/reg_dst_decoder.sv
// Combinational register-address extraction: sources, real destination,
// write-enable, load flag and whether rt is read as a source.
module reg_dst_decoder
  import mips_pkg::*;
#(
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned REG_ADDR_W = REG_W,
  parameter int unsigned LINK_REG   = 31
) (
  input  logic [INSTR_W-1:0]    instr_i,
  output logic [REG_ADDR_W-1:0] rs_o,
  output logic [REG_ADDR_W-1:0] rt_o,
  output logic [REG_ADDR_W-1:0] dst_o,
  output logic                  we_o,
  output logic                  is_load_o,
  output logic                  rt_used_o
);

  logic [OPCODE_W-1:0]   op;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] dst_raw;
  logic                  we_raw;
  logic                  ld_raw;
  logic                  unused_shamt;

  assign op           = instr_i[INSTR_W-1 -: OPCODE_W];
  assign funct        = instr_i[5:0];
  assign rs_o         = instr_i[25:21];
  assign rt_o         = instr_i[20:16];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    dst_raw = '0;
    we_raw  = 1'b0;
    ld_raw  = 1'b0;
    if (op == OP_RTYPE) begin
      dst_raw = instr_i[15:11];
      we_raw  = (funct != FUNCT_JR);
    end else if (op_in_range(op, OP_ADDI, OP_LUI)) begin
      dst_raw = rt_o;
      we_raw  = 1'b1;
    end else if (op_in_range(op, OP_LB, OP_LHU)) begin
      dst_raw = rt_o;
      we_raw  = 1'b1;
      ld_raw  = 1'b1;
    end else if (op == OP_JAL) begin
      dst_raw = REG_ADDR_W'(LINK_REG);
      we_raw  = 1'b1;
    end
  end

  // $zero is never a real destination, so it can neither be written nor stall.
  assign dst_o     = dst_raw;
  assign we_o      = we_raw && (dst_raw != '0);
  assign is_load_o = ld_raw && (dst_raw != '0);
  assign rt_used_o = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
                     op_in_range(op, OP_SB, OP_SW);

endmodule

// File: rtl/reg_addr_decode_stage.sv
// Registered register-address decode stage with valid/ready handshake and
// load-use stall over the output register plus HAZARD_DEPTH-1 history slots.
module reg_addr_decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned INSTR_W      = 32,
  parameter int unsigned REG_ADDR_W   = REG_W,
  parameter int unsigned LINK_REG     = 31,
  parameter int unsigned HAZARD_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] rs_addr,
  output logic [REG_ADDR_W-1:0] rt_addr,
  output logic [REG_ADDR_W-1:0] dst_addr,
  output logic                  dst_we,
  output logic                  is_load,
  output logic                  hazard
);

  logic [REG_ADDR_W-1:0] dec_rs, dec_rt, dec_dst;
  logic                  dec_we, dec_ld, dec_rt_used;

  reg_dst_decoder #(
    .INSTR_W   (INSTR_W),
    .REG_ADDR_W(REG_ADDR_W),
    .LINK_REG  (LINK_REG)
  ) u_dec (
    .instr_i  (instr),
    .rs_o     (dec_rs),
    .rt_o     (dec_rt),
    .dst_o    (dec_dst),
    .we_o     (dec_we),
    .is_load_o(dec_ld),
    .rt_used_o(dec_rt_used)
  );

  logic                  out_valid_q, out_valid_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, dst_q, dst_d;
  logic                  we_q, we_d, ld_q, ld_d;
  logic                  hit;
  logic                  accept;

  sb_entry_t slot [HAZARD_DEPTH];

  assign slot[0] = '{valid: out_valid_q && ld_q, addr: dst_q};

  if (HAZARD_DEPTH > 1) begin : g_sb
    sb_entry_t sb_q [HAZARD_DEPTH-1];
    sb_entry_t sb_d [HAZARD_DEPTH-1];

    // History only moves when the output register drains (or sits empty).
    always_comb begin
      sb_d = sb_q;
      if (out_ready) begin
        sb_d[0] = out_valid_q ? slot[0] : '0;
        for (int i = 1; i < HAZARD_DEPTH - 1; i++) sb_d[i] = sb_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < HAZARD_DEPTH - 1; i++) sb_q[i] <= '0;
      end else begin
        sb_q <= sb_d;
      end
    end

    for (genvar g = 1; g < HAZARD_DEPTH; g++) begin : g_slot
      assign slot[g] = sb_q[g-1];
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (slot[i].valid && (slot[i].addr != REG_ZERO) &&
          ((slot[i].addr == dec_rs) || (dec_rt_used && (slot[i].addr == dec_rt))))
        hit = 1'b1;
    end
  end

  assign hazard   = in_valid && hit;
  assign in_ready = !rst && (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dst_d       = dst_q;
    we_d        = we_q;
    ld_d        = ld_q;
    if (accept) begin
      out_valid_d = 1'b1;
      rs_d        = dec_rs;
      rt_d        = dec_rt;
      dst_d       = dec_dst;
      we_d        = dec_we;
      ld_d        = dec_ld;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses <= so every register samples the pre-edge values.
    if (rst) begin
      out_valid_q <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      dst_q       <= '0;
      we_q        <= 1'b0;
      ld_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dst_q       <= dst_d;
      we_q        <= we_d;
      ld_q        <= ld_d;
    end
  end

  assign out_valid = out_valid_q;
  assign rs_addr   = rs_q;
  assign rt_addr   = rt_q;
  assign dst_addr  = dst_q;
  assign dst_we    = we_q;
  assign is_load   = ld_q;

endmodule

// File: tb/tb_reg_addr_decode_stage.sv
// Self-checking bench: directed plan steps and random traffic against a
// cycle-level reference model, plus a depth-2 instance for the long stall.
module tb_reg_addr_decode_stage;

  localparam int HD = 1;

  localparam logic [31:0] I_ADD3  = 32'h0022_1820;  // add $3,$1,$2
  localparam logic [31:0] I_LW5   = 32'h8C85_0000;  // lw  $5,0($4)
  localparam logic [31:0] I_ADD6  = 32'h00A1_3020;  // add $6,$5,$1
  localparam logic [31:0] I_JAL   = 32'h0C00_0010;
  localparam logic [31:0] I_JR31  = 32'h03E0_0008;
  localparam logic [31:0] I_ADD8  = 32'h00E7_4020;  // add $8,$7,$7
  localparam logic [31:0] I_LW0   = 32'h8C80_0000;  // lw  $0,0($4)
  localparam logic [31:0] I_ADDZ  = 32'h0000_3020;  // add $6,$0,$0
  localparam logic [31:0] I_ADDR0 = 32'h0022_0020;  // add $0,$1,$2

  typedef struct packed {
    logic [4:0] rs, rt, dst;
    logic       we, ld, rt_used;
  } dec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, in_ready, out_valid, dst_we, is_load, hazard;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr, dst_addr;

  logic        b_rst, b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_dst_we, b_is_load, b_hazard;
  logic [31:0] b_instr;
  logic [4:0]  b_rs_addr, b_rt_addr, b_dst_addr;

  reg_addr_decode_stage #(.HAZARD_DEPTH(HD)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .dst_addr(dst_addr), .dst_we(dst_we), .is_load(is_load), .hazard(hazard)
  );

  reg_addr_decode_stage #(.HAZARD_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .instr(b_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
    .dst_addr(b_dst_addr), .dst_we(b_dst_we), .is_load(b_is_load), .hazard(b_hazard)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: output register contents and load history.
  logic       m_valid;
  dec_t       m_out;
  logic [5:0] m_sb[$];
  logic       last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [5:0] op;
    op        = ins[31:26];
    d.rs      = ins[25:21];
    d.rt      = ins[20:16];
    d.dst     = 5'd0;
    d.we      = 1'b0;
    d.ld      = 1'b0;
    d.rt_used = (op == 6'h00) || (op inside {6'h04, 6'h05}) || (op inside {[6'h28:6'h2B]});
    if (op == 6'h00) begin
      d.dst = ins[15:11];
      d.we  = (ins[5:0] != 6'h08);
    end else if (op inside {[6'h08:6'h0F]}) begin
      d.dst = ins[20:16];
      d.we  = 1'b1;
    end else if (op inside {[6'h20:6'h25]}) begin
      d.dst = ins[20:16];
      d.we  = 1'b1;
      d.ld  = 1'b1;
    end else if (op == 6'h03) begin
      d.dst = 5'd31;
      d.we  = 1'b1;
    end
    if (d.dst == 5'd0) begin
      d.we = 1'b0;
      d.ld = 1'b0;
    end
    return d;
  endfunction

  function automatic logic hits(input logic v, input logic [4:0] a, input dec_t d);
    return v && (a != 5'd0) && ((a == d.rs) || (d.rt_used && (a == d.rt)));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [17];
    logic [5:0] op, funct;
    ops = '{6'h00, 6'h00, 6'h00, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h0F,
            6'h20, 6'h23, 6'h25, 6'h28, 6'h2B, 6'h02, 6'h3F, 6'h1A};
    op    = ops[$urandom_range(0, 16)];
    funct = ($urandom_range(0, 7) == 0) ? 6'h08 : 6'($urandom);
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom), funct};
  endfunction

  // One clock cycle on the main instance: compare at the falling edge, then
  // advance the model across the rising edge. Returns at posedge + 1.
  task automatic tick();
    dec_t d;
    logic exp_haz, exp_rdy;
    logic [5:0] head;
    @(negedge clk);
    d       = decode(instr);
    exp_haz = in_valid && (hits(m_valid && m_out.ld, m_out.dst, d) ||
              (m_sb.size() > 0 && 1'b0));
    foreach (m_sb[i]) if (in_valid && hits(m_sb[i][5], m_sb[i][4:0], d)) exp_haz = 1'b1;
    exp_rdy = !rst && (!m_valid || out_ready) && !exp_haz;
    chk("hazard", hazard, exp_haz);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("rs_addr", rs_addr, m_out.rs);
      chk("rt_addr", rt_addr, m_out.rt);
      chk("dst_addr", dst_addr, m_out.dst);
      chk("dst_we", dst_we, m_out.we);
      chk("is_load", is_load, m_out.ld);
    end
    last_acc = in_ready;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_out   = '0;
      foreach (m_sb[i]) m_sb[i] = 6'h0;
    end else begin
      if (out_ready && HD > 1) begin
        head = m_valid ? {m_out.ld, m_out.dst} : 6'h0;
        m_sb.push_front(head);
        void'(m_sb.pop_back());
      end
      if (in_valid && exp_rdy) begin
        m_valid = 1'b1;
        m_out   = d;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, output int stalls);
    instr    = ins;
    in_valid = 1'b1;
    stalls   = 0;
    last_acc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_acc) break;
      stalls++;
    end
    in_valid = 1'b0;
    chk("accept_seen", last_acc, 1'b1);
  endtask

  initial begin
    int   stalls;
    logic acc, haz;

    m_valid = 1'b0;
    m_out   = '0;
    for (int i = 0; i < HD - 1; i++) m_sb.push_back(6'h0);

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instr = I_ADD3;
    b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b1; b_instr = '0;
    tick();
    tick();
    chk("rst_in_ready", last_acc, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_fields", {rs_addr, rt_addr, dst_addr, dst_we, is_load}, 17'h0);

    // Basic R-type, one-cycle latency.
    issue(I_ADD3, stalls);
    chk("add_stalls", stalls, 0);
    chk("add_out_valid", out_valid, 1'b1);
    chk("add_fields", {rs_addr, rt_addr, dst_addr, dst_we, is_load}, {5'd1, 5'd2, 5'd3, 1'b1, 1'b0});

    // Load-use: exactly one bubble at depth 1.
    issue(I_LW5, stalls);
    chk("lw_is_load", is_load, 1'b1);
    issue(I_ADD6, stalls);
    chk("lw_use_stalls", stalls, 1);
    chk("lw_use_dst", dst_addr, 5'd6);

    // JAL writes the link register; JR reading it does not stall.
    issue(I_JAL, stalls);
    chk("jal_dst_we", {dst_addr, dst_we}, {5'd31, 1'b1});
    issue(I_JR31, stalls);
    chk("jr_stalls", stalls, 0);
    chk("jr_we", {rs_addr, dst_we}, {5'd31, 1'b0});

    // Backpressure: outputs held, no accept, then drain and accept together.
    issue(I_ADD3, stalls);
    out_ready = 1'b0; instr = I_ADD8; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready", last_acc, 1'b0);
      chk("bp_held", {out_valid, dst_addr, rs_addr}, {1'b1, 5'd3, 5'd1});
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_drain_accept", last_acc, 1'b1);
    chk("bp_new_dst", dst_addr, 5'd8);

    // $zero destinations.
    issue(I_LW0, stalls);
    chk("lw0_we_ld", {dst_we, is_load}, 2'b00);
    issue(I_ADDZ, stalls);
    chk("zero_read_stalls", stalls, 0);
    issue(I_ADDR0, stalls);
    chk("rd0_we", dst_we, 1'b0);

    // Reset while a load is held clears the scoreboard.
    issue(I_LW5, stalls);
    out_ready = 1'b0; rst = 1'b1;
    tick();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_fields", {rs_addr, rt_addr, dst_addr, dst_we, is_load}, 17'h0);
    rst = 1'b0; out_ready = 1'b1;
    issue(I_ADD6, stalls);
    chk("midrst_no_stall", stalls, 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      instr     = rand_instr();
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Depth-2 instance: load-use costs two bubbles.
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(posedge clk); #1;
    b_instr = I_LW5; b_in_valid = 1'b1;
    @(negedge clk);
    chk("d2_lw_ready", b_in_ready, 1'b1);
    @(posedge clk); #1;
    b_instr = I_ADD6;
    stalls  = 0;
    acc     = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      haz = b_hazard;
      acc = b_in_ready;
      @(posedge clk); #1;
      if (acc) break;
      chk("d2_stall_hazard", haz, 1'b1);
      stalls++;
    end
    b_in_valid = 1'b0;
    chk("d2_accept_seen", acc, 1'b1);
    chk("d2_stalls", stalls, 2);
    chk("d2_add_dst", {b_out_valid, b_dst_addr}, {1'b1, 5'd6});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
